// File: rtl/npu_wr_sched.sv
// npu_wr_sched: grants one requester (binner or loader) a whole frame of pixel writes, then pulses npu_start.
// Latency: one cycle from an accepted in-range transfer to npu_write_en with registered npu_addr/npu_data.
// Backpressure: only the frame owner sees ready, and only in FILL; both readies are low in IDLE/START/WAIT.
// Option: define NPU_WR_SCHED_TIMEOUT_EN to abort a frame after 1024 transfer-free cycles in FILL.
module npu_wr_sched #(
   parameter int NUM_PIXELS = 3072,
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8
) (
   input  logic              npu_clk,
   input  logic              npu_rst,
   input  logic              bin_valid,
   input  logic [ADDR_W-1:0] bin_addr,
   input  logic [DATA_W-1:0] bin_data,
   output logic              bin_ready,
   input  logic              ldr_valid,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_data,
   output logic              ldr_ready,
   output logic              npu_write_en,
   output logic [ADDR_W-1:0] npu_addr,
   output logic [DATA_W-1:0] npu_data,
   output logic              npu_start,
   input  logic              npu_done,
   output logic              err_addr,
   output logic              timeout_err
);

   localparam int                CNT_W      = $clog2(NUM_PIXELS + 1);
   localparam int                LIM_W      = ADDR_W + 1;
   localparam logic [LIM_W-1:0]  ADDR_LIMIT = LIM_W'(NUM_PIXELS);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, FILL, START, WAIT} state_t;

   state_t            state, state_nxt;
   logic              owner, owner_nxt;   // 0: binner, 1: loader
   logic [CNT_W-1:0]  count;
   logic              sel_valid;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              in_range;
   logic              xfer;
   logic              wr_fire;
   logic              abort;

   // Only the owner's request is ever looked at; the other side simply sees ready low.
   assign sel_valid = owner ? ldr_valid : bin_valid;
   assign sel_addr  = owner ? ldr_addr  : bin_addr;
   assign sel_data  = owner ? ldr_data  : bin_data;
   assign in_range  = {1'b0, sel_addr} < ADDR_LIMIT;
   assign xfer      = (state == FILL) && sel_valid;
   assign wr_fire   = xfer && in_range;

   // State and owner registers; reset abandons any frame in flight.
   always_ff @(posedge npu_clk) begin
      if (npu_rst) begin
         state <= IDLE;
         owner <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   // Next-state, ownership grant and handshake outputs.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      bin_ready = 1'b0;
      ldr_ready = 1'b0;
      npu_start = 1'b0;
      case (state)
         IDLE: begin
            // Binner has priority when both ask in the same cycle.
            if (bin_valid) begin
               owner_nxt = 1'b0;
               state_nxt = FILL;
            end else if (ldr_valid) begin
               owner_nxt = 1'b1;
               state_nxt = FILL;
            end
         end
         FILL: begin
            bin_ready = ~owner;
            ldr_ready = owner;
            if (wr_fire && (count == CNT_LAST)) begin
               state_nxt = START;
            end else if (abort) begin
               owner_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         START: begin
            // Coincides with the final write, which is registered one cycle after its transfer.
            npu_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (npu_done) begin
               owner_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame write counter: counts accepted in-range writes, duplicates included.
   always_ff @(posedge npu_clk) begin
      if (npu_rst) begin
         count <= '0;
      end else if (((state == WAIT) && npu_done) || abort) begin
         count <= '0;
      end else if (wr_fire) begin
         count <= count + CNT_W'(1);
      end
   end

   // NPU write port and sticky address error; out-of-range beats are consumed silently.
   always_ff @(posedge npu_clk) begin
      if (npu_rst) begin
         npu_write_en <= 1'b0;
         npu_addr     <= '0;
         npu_data     <= '0;
         err_addr     <= 1'b0;
      end else begin
         npu_write_en <= wr_fire;
         if (wr_fire) begin
            npu_addr <= sel_addr;
            npu_data <= sel_data;
         end
         if (xfer && !in_range) begin
            err_addr <= 1'b1;
         end
      end
   end

`ifdef NPU_WR_SCHED_TIMEOUT_EN
   logic [9:0] idle_cnt;

   // Abort on the 1024th consecutive transfer-free cycle of FILL.
   assign abort = (state == FILL) && !xfer && (idle_cnt == 10'd1023);

   // Idle-cycle counter, restarted by every transfer and outside FILL.
   always_ff @(posedge npu_clk) begin
      if (npu_rst || (state != FILL) || xfer) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 10'd1;
      end
   end

   // Sticky record that a frame was dropped for inactivity.
   always_ff @(posedge npu_clk) begin
      if (npu_rst) begin
         timeout_err <= 1'b0;
      end else if (abort) begin
         timeout_err <= 1'b1;
      end
   end
`else
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule
